// File: rtl/alu_issue_stage.sv
//------------------------------------------------------------------------------
// Module   : alu_issue_stage
// Brief    : RV32I decode/issue stage feeding the ALU through a 2-entry skid buffer.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package risc_pkg;
    typedef enum logic [3:0] {
        ADD_op  = 4'd0,
        SUB_op  = 4'd1,
        SLL_op  = 4'd2,
        SLT_op  = 4'd3,
        SLTU_op = 4'd4,
        XOR_op  = 4'd5,
        SRL_op  = 4'd6,
        SRA_op  = 4'd7,
        OR_op   = 4'd8,
        AND_op  = 4'd9
    } alu_op_t;
endpackage

module alu_issue_stage #(
    parameter int XLEN = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [31:0]          in_instr,
    input  logic [XLEN-1:0]      in_pc,
    input  logic [XLEN-1:0]      rs1_data,
    input  logic [XLEN-1:0]      rs2_data,
    input  logic                 flush,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [XLEN-1:0]      alu_a,
    output logic [XLEN-1:0]      alu_b,
    output risc_pkg::alu_op_t    alu_op,
    output logic [4:0]           rd,
    output logic                 rd_we,
    output logic                 illegal
);
    import risc_pkg::*;

    localparam logic [6:0] c_OPC_OP    = 7'b0110011;
    localparam logic [6:0] c_OPC_IMM   = 7'b0010011;
    localparam logic [6:0] c_OPC_LUI   = 7'b0110111;
    localparam logic [6:0] c_OPC_AUIPC = 7'b0010111;
    localparam logic [6:0] c_F7_ZERO   = 7'b0000000;
    localparam logic [6:0] c_F7_ALT    = 7'b0100000;

    typedef struct packed {
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
        alu_op_t         op;
        logic [4:0]      rd;
        logic            rd_we;
        logic            illegal;
    } entry_t;

    localparam entry_t c_ENTRY_RESET = '{a: '0, b: '0, op: ADD_op, rd: 5'd0, rd_we: 1'b0, illegal: 1'b0};

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_FULL  = 2'd2
    } state_t;

    state_t          r_state;
    entry_t          r_main;
    entry_t          r_skid;
    logic            r_out_valid;
    logic            r_in_ready;

    logic [6:0]      w_opcode;
    logic [2:0]      w_funct3;
    logic [6:0]      w_funct7;
    logic [XLEN-1:0] w_imm_i;
    logic [XLEN-1:0] w_imm_u;
    logic [XLEN-1:0] w_shamt;
    logic [XLEN-1:0] w_a;
    logic [XLEN-1:0] w_b;
    alu_op_t         w_op;
    logic            w_legal;
    entry_t          w_dec;
    logic            w_accept;
    logic            w_issue;
    logic            w_unused;

    function automatic alu_op_t f3_op(input logic [2:0] f3);
        case (f3)
            3'b000:  return ADD_op;
            3'b001:  return SLL_op;
            3'b010:  return SLT_op;
            3'b011:  return SLTU_op;
            3'b100:  return XOR_op;
            3'b101:  return SRL_op;
            3'b110:  return OR_op;
            default: return AND_op;
        endcase
    endfunction

    assign w_opcode = in_instr[6:0];
    assign w_funct3 = in_instr[14:12];
    assign w_funct7 = in_instr[31:25];
    assign w_imm_i  = {{(XLEN-12){in_instr[31]}}, in_instr[31:20]};
    assign w_imm_u  = {{(XLEN-31){in_instr[31]}}, in_instr[30:12], 12'b0};
    assign w_shamt  = {{(XLEN-5){1'b0}}, in_instr[24:20]};
    // rs1 index is consumed by the register file, not by this stage
    assign w_unused = ^in_instr[19:15];

    always_comb begin
        w_a     = '0;
        w_b     = '0;
        w_op    = ADD_op;
        w_legal = 1'b1;
        case (w_opcode)
            c_OPC_OP: begin
                w_a  = rs1_data;
                w_b  = rs2_data;
                w_op = f3_op(w_funct3);
                if (w_funct7 == c_F7_ALT) begin
                    if (w_funct3 == 3'b000)      w_op = SUB_op;
                    else if (w_funct3 == 3'b101) w_op = SRA_op;
                    else                         w_legal = 1'b0;
                end else if (w_funct7 != c_F7_ZERO) begin
                    w_legal = 1'b0;
                end
            end
            c_OPC_IMM: begin
                w_a  = rs1_data;
                w_b  = w_imm_i;
                w_op = f3_op(w_funct3);
                if (w_funct3 == 3'b001) begin
                    w_b = w_shamt;
                    if (w_funct7 != c_F7_ZERO) w_legal = 1'b0;
                end else if (w_funct3 == 3'b101) begin
                    w_b = w_shamt;
                    if (w_funct7 == c_F7_ALT)       w_op = SRA_op;
                    else if (w_funct7 != c_F7_ZERO) w_legal = 1'b0;
                end
            end
            c_OPC_LUI: begin
                w_b = w_imm_u;
            end
            c_OPC_AUIPC: begin
                w_a = in_pc;
                w_b = w_imm_u;
            end
            default: w_legal = 1'b0;
        endcase
        // Undecodable entries carry neutral operands so downstream sees a harmless ADD
        if (!w_legal) begin
            w_a  = '0;
            w_b  = '0;
            w_op = ADD_op;
        end
    end

    assign w_dec = '{a: w_a, b: w_b, op: w_op, rd: in_instr[11:7],
                     rd_we: w_legal && (in_instr[11:7] != 5'd0), illegal: !w_legal};

    assign w_accept = in_valid && r_in_ready;
    assign w_issue  = r_out_valid && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_EMPTY;
            r_main      <= c_ENTRY_RESET;
            r_skid      <= c_ENTRY_RESET;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
        end else if (flush) begin
            r_state     <= S_EMPTY;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
        end else begin
            case (r_state)
                S_EMPTY: begin
                    if (w_accept) begin
                        r_main      <= w_dec;
                        r_state     <= S_ONE;
                        r_out_valid <= 1'b1;
                    end
                end
                S_ONE: begin
                    if (w_accept && !w_issue) begin
                        r_skid     <= w_dec;
                        r_state    <= S_FULL;
                        r_in_ready <= 1'b0;
                    end else if (w_issue && !w_accept) begin
                        r_state     <= S_EMPTY;
                        r_out_valid <= 1'b0;
                    end else if (w_accept) begin
                        r_main <= w_dec;
                    end
                end
                S_FULL: begin
                    if (w_issue) begin
                        r_main     <= r_skid;
                        r_state    <= S_ONE;
                        r_in_ready <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= S_EMPTY;
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign alu_a     = r_main.a;
    assign alu_b     = r_main.b;
    assign alu_op    = r_main.op;
    assign rd        = r_main.rd;
    assign rd_we     = r_main.rd_we;
    assign illegal   = r_main.illegal;

endmodule

`default_nettype wire

// File: tb/tb_alu_issue_stage.sv
//------------------------------------------------------------------------------
// Module   : tb_alu_issue_stage
// Brief    : Self-checking bench for alu_issue_stage against a queue-based model.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_alu_issue_stage;
    import risc_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    alu_op_t     alu_op;
    logic [4:0]  rd;
    logic        rd_we;
    logic        illegal;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        alu_op_t     op;
        logic [4:0]  rd;
        logic        we;
        logic        ill;
    } exp_t;

    exp_t q[$];

    alu_issue_stage #(.XLEN(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
        .rs1_data(rs1_data), .rs2_data(rs2_data), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .rd(rd), .rd_we(rd_we), .illegal(illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference decode straight from the ISA rules: legality first, then fields.
    function automatic exp_t m_decode(input logic [31:0] ins, input logic [31:0] pc,
                                      input logic [31:0] r1, input logic [31:0] r2);
        exp_t e;
        logic [6:0] opc = ins[6:0];
        logic [2:0] f3  = ins[14:12];
        logic [6:0] f7  = ins[31:25];
        bit is_op    = (opc == 7'h33);
        bit is_imm   = (opc == 7'h13);
        bit is_lui   = (opc == 7'h37);
        bit is_auipc = (opc == 7'h17);
        bit is_shimm = is_imm && (f3 == 3'd1 || f3 == 3'd5);
        bit legal;
        if (is_op)       legal = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
        else if (is_imm) legal = (f3 == 3'd1) ? (f7 == 7'h00)
                               : (f3 == 3'd5) ? (f7 == 7'h00 || f7 == 7'h20) : 1'b1;
        else             legal = is_lui || is_auipc;
        case (f3)
            3'd0: e.op = ADD_op;
            3'd1: e.op = SLL_op;
            3'd2: e.op = SLT_op;
            3'd3: e.op = SLTU_op;
            3'd4: e.op = XOR_op;
            3'd5: e.op = SRL_op;
            3'd6: e.op = OR_op;
            default: e.op = AND_op;
        endcase
        if (is_op && f7 == 7'h20) e.op = (f3 == 3'd0) ? SUB_op : SRA_op;
        if (is_imm && f3 == 3'd5 && f7 == 7'h20) e.op = SRA_op;
        if (is_lui || is_auipc || !legal) e.op = ADD_op;
        e.a = (is_op || is_imm) ? r1 : (is_auipc ? pc : 32'd0);
        if (is_op)         e.b = r2;
        else if (is_shimm) e.b = 32'(ins[24:20]);
        else if (is_imm)   e.b = 32'($signed(ins[31:20]));
        else               e.b = {ins[31:12], 12'h000};
        if (!legal) begin
            e.a = 32'd0;
            e.b = 32'd0;
        end
        e.rd  = ins[11:7];
        e.we  = legal && (ins[11:7] != 5'd0);
        e.ill = !legal;
        return e;
    endfunction

    // Compare process: outputs against the model head, then advance the model to the next edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            q.delete();
            chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
            chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        end else begin
            bit acc, iss;
            chk("out_valid", {31'd0, out_valid}, {31'd0, q.size() > 0});
            chk("in_ready", {31'd0, in_ready}, {31'd0, q.size() < 2});
            if (q.size() > 0) begin
                chk("alu_op", 32'(alu_op), 32'(q[0].op));
                chk("rd", {27'd0, rd}, {27'd0, q[0].rd});
                chk("rd_we", {31'd0, rd_we}, {31'd0, q[0].we});
                chk("illegal", {31'd0, illegal}, {31'd0, q[0].ill});
                if (!q[0].ill) begin
                    chk("alu_a", alu_a, q[0].a);
                    chk("alu_b", alu_b, q[0].b);
                end
            end
            acc = in_valid && (q.size() < 2);
            iss = (q.size() > 0) && out_ready;
            if (flush) begin
                q.delete();
            end else begin
                if (iss) void'(q.pop_front());
                if (acc) q.push_back(m_decode(in_instr, in_pc, rs1_data, rs2_data));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] r1, input logic [31:0] r2);
        in_valid = v;
        in_instr = ins;
        rs1_data = r1;
        rs2_data = r2;
        in_pc    = 32'h0000_1000;
    endtask

    task automatic chk_out(input string name, input logic [31:0] a, input logic [31:0] b,
                           input alu_op_t op, input logic [4:0] r, input logic we);
        chk({name, "_valid"}, {31'd0, out_valid}, 32'd1);
        chk({name, "_a"}, alu_a, a);
        chk({name, "_b"}, alu_b, b);
        chk({name, "_op"}, 32'(alu_op), 32'(op));
        chk({name, "_rd"}, {27'd0, rd}, {27'd0, r});
        chk({name, "_we"}, {31'd0, rd_we}, {31'd0, we});
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] ins = $urandom;
        case ($urandom_range(0, 5))
            0: ins[6:0] = 7'h33;
            1: ins[6:0] = 7'h13;
            2: ins[6:0] = 7'h37;
            3: ins[6:0] = 7'h17;
            4: ins[6:0] = 7'($urandom);
            default: begin
                ins[6:0]   = 7'h13;
                ins[14:12] = $urandom_range(0, 1) ? 3'd1 : 3'd5;
            end
        endcase
        case ($urandom_range(0, 3))
            0: ins[31:25] = 7'h00;
            1: ins[31:25] = 7'h20;
            2: ins[31:25] = 7'h00;
            default: ;
        endcase
        return ins;
    endfunction

    initial begin
        rst_n = 1'b0; flush = 1'b0; out_ready = 1'b1;
        drive(1'b0, 32'd0, 32'd0, 32'd0);
        #12;
        chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
        chk("reset_in_ready", {31'd0, in_ready}, 32'd1);
        chk("reset_a", alu_a, 32'd0);
        chk("reset_b", alu_b, 32'd0);
        chk("reset_op", 32'(alu_op), 32'(ADD_op));
        chk("reset_rd", {27'd0, rd}, 32'd0);
        chk("reset_we", {31'd0, rd_we}, 32'd0);
        chk("reset_illegal", {31'd0, illegal}, 32'd0);
        @(posedge clk); #2 rst_n = 1'b1;
        step();

        // ADD x3,x1,x2 with one-cycle latency
        drive(1'b1, 32'h002081B3, 32'd5, 32'd7);
        step();
        chk_out("add", 32'd5, 32'd7, ADD_op, 5'd3, 1'b1);

        // Immediate forms back-to-back
        drive(1'b1, 32'hFFF00093, 32'd0, 32'd0);
        step();
        chk_out("addi", 32'd0, 32'hFFFF_FFFF, ADD_op, 5'd1, 1'b1);
        drive(1'b1, 32'h40435293, 32'h8000_0000, 32'd0);
        step();
        chk_out("srai", 32'h8000_0000, 32'd4, SRA_op, 5'd5, 1'b1);
        drive(1'b1, 32'h123450B7, 32'd9, 32'd9);
        step();
        chk_out("lui", 32'd0, 32'h1234_5000, ADD_op, 5'd1, 1'b1);
        in_valid = 1'b0;
        step();

        // Backpressure: two accepted, third waits for the first issue
        out_ready = 1'b0;
        drive(1'b1, 32'h002081B3, 32'd1, 32'd2);
        step();
        chk("bp_ready1", {31'd0, in_ready}, 32'd1);
        drive(1'b1, 32'h00A00213, 32'd3, 32'd0);
        step();
        chk("bp_ready2", {31'd0, in_ready}, 32'd0);
        drive(1'b1, 32'h00500393, 32'd4, 32'd0);
        step();
        chk_out("bp_hold", 32'd1, 32'd2, ADD_op, 5'd3, 1'b1);
        out_ready = 1'b1;
        step();
        chk_out("bp_second", 32'd3, 32'd10, ADD_op, 5'd4, 1'b1);
        step();
        in_valid = 1'b0;
        chk_out("bp_third", 32'd4, 32'd5, ADD_op, 5'd7, 1'b1);
        step();

        // Illegal encodings still pass the handshake
        drive(1'b1, 32'h0000007F, 32'd1, 32'd1);
        step();
        chk("ill1", {31'd0, illegal}, 32'd1);
        chk("ill1_we", {31'd0, rd_we}, 32'd0);
        chk("ill1_op", 32'(alu_op), 32'(ADD_op));
        drive(1'b1, 32'h60208033, 32'd1, 32'd1);
        step();
        chk("ill2", {31'd0, illegal}, 32'd1);
        chk("ill2_valid", {31'd0, out_valid}, 32'd1);
        in_valid = 1'b0;
        step();

        // Flush while full with a third instruction offered
        out_ready = 1'b0;
        drive(1'b1, 32'h002081B3, 32'd1, 32'd1);
        step();
        drive(1'b1, 32'h00100093, 32'd1, 32'd1);
        step();
        drive(1'b1, 32'h00200113, 32'd1, 32'd1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        chk("flush_valid", {31'd0, out_valid}, 32'd0);
        chk("flush_ready", {31'd0, in_ready}, 32'd1);
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("flush_never_issued", {31'd0, out_valid}, 32'd0);
        end

        // Asynchronous reset in the middle of a full stall
        out_ready = 1'b0;
        drive(1'b1, 32'h002081B3, 32'd11, 32'd12);
        step();
        drive(1'b1, 32'h00100093, 32'd1, 32'd1);
        step();
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", {31'd0, out_valid}, 32'd0);
        chk("arst_ready", {31'd0, in_ready}, 32'd1);
        chk("arst_a", alu_a, 32'd0);
        chk("arst_rd", {27'd0, rd}, 32'd0);
        @(posedge clk); #2 rst_n = 1'b1;
        step();
        out_ready = 1'b1;
        drive(1'b1, 32'h002081B3, 32'd5, 32'd7);
        step();
        in_valid = 1'b0;
        chk_out("post_rst", 32'd5, 32'd7, ADD_op, 5'd3, 1'b1);
        step();

        // Randomized traffic against the model
        for (int i = 0; i < 2000; i++) begin
            drive($urandom_range(0, 9) < 7, rand_instr(), $urandom, $urandom);
            in_pc     = $urandom;
            out_ready = $urandom_range(0, 9) < 6;
            flush     = $urandom_range(0, 49) == 0;
            step();
        end
        flush = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (4) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
- Decode/issue stage that produces the ALU's operand and opcode inputs from an RV32I instruction word and register-file read data. It is the producing end of the ALU interface.
- Registers its outputs behind a valid/ready handshake with a 2-entry skid buffer, so in_ready is driven from a flop.
- Sits between fetch/register read and the ALU/execute stage. Supports flush for branch redirects.

Parameters:
- XLEN, 32, datapath width; only 32 is supported.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  upstream instruction valid
- in_ready  out  1  stage can accept this cycle
- in_instr  in  32  instruction word
- in_pc  in  32  instruction PC
- rs1_data  in  32  register file read data, rs1
- rs2_data  in  32  register file read data, rs2
- flush  in  1  discard all held and incoming instructions
- out_valid  out  1  issue slot valid
- out_ready  in  1  execute stage accepts
- alu_a  out  32  ALU operand A
- alu_b  out  32  ALU operand B
- alu_op  out  alu_op_t  ALU operation (risc_pkg)
- rd  out  5  destination register
- rd_we  out  1  writeback enable
- illegal  out  1  instruction not decodable by this stage

Behaviour:
- Reset (async assert, sync release):
  - out_valid=0, in_ready=1, alu_a=0, alu_b=0, alu_op=ADD_op, rd=0, rd_we=0, illegal=0.
  - Both buffer entries are invalidated.
- Handshakes:
  - Accept when in_valid&&in_ready.
  - Issue when out_valid&&out_ready.
  - Output fields stay stable while out_valid&&!out_ready.
- Latency: 1 cycle from accept to out_valid when the stage is empty.
- Occupancy state machine:
  - EMPTY: on accept -> ONE.
  - ONE: accept&&!issue -> FULL (new entry goes to skid). issue&&!accept -> EMPTY. Both or neither -> ONE (main reloads on simultaneous accept).
  - FULL: in_ready=0. On issue, skid moves to main -> ONE.
  - in_ready = (state!=FULL), registered.
  - Strict FIFO order: no entry is lost or duplicated.
- Flush has priority over everything: next cycle state=EMPTY and out_valid=0. An instruction accepted in the flush cycle is discarded. in_ready=1 in the cycle after flush.
- Decode (performed at accept; the result is what gets buffered):
  - OP (0110011):
    - a=rs1, b=rs2.
    - funct3 000/001/010/011/100/101/110/111 -> ADD/SLL/SLT/SLTU/XOR/SRL/OR/AND.
    - funct7=0100000 is legal only with funct3 000 (SUB_op) or 101 (SRA_op).
    - Any other funct7 other than 0000000 -> illegal.
  - OP-IMM (0010011):
    - a=rs1, b=sign-extended instr[31:20].
    - Same funct3 mapping as OP, except 000 is always ADD.
    - SLLI requires funct7=0000000.
    - funct3=101: funct7 0000000 -> SRL, 0100000 -> SRA, else illegal.
    - For shifts, b = zero-extended instr[24:20].
  - LUI (0110111): a=0, b={instr[31:12],12'b0}, ADD_op.
  - AUIPC (0010111): a=in_pc, b={instr[31:12],12'b0}, ADD_op.
  - Any other opcode -> illegal=1, alu_op=ADD_op, a=b=0, rd_we=0.
  - rd = instr[11:7].
  - rd_we = !illegal && rd!=0.
- An illegal instruction still flows through the handshake like any other entry. Trapping is downstream's responsibility.

Test Plan:
- ADD x3,x1,x2: 0x002081B3, rs1=5, rs2=7 -> one cycle later out_valid=1, alu_op=ADD_op, a=5, b=7, rd=3, rd_we=1.
- Immediate decode, sent back-to-back with out_ready=1:
  - ADDI x1,x0,-1: 0xFFF00093 -> b=0xFFFFFFFF.
  - SRAI x5,x6,4: 0x40435293 -> SRA_op, b=4.
  - LUI x1,0x12345: 0x123450B7 -> a=0, b=0x12345000.
  - Each appears on consecutive cycles.
- Backpressure: out_ready=0, offer 3 instructions -> 2 accepted, then in_ready=0. Raise out_ready -> issued in original order, third accepted after the first issue.
- Illegal: 0x0000007F and 0x60208033 -> illegal=1, rd_we=0, alu_op=ADD_op; each passes the handshake normally.
- Flush with FULL state and in_valid=1 in the same cycle -> next cycle out_valid=0, in_ready=1, and none of the 3 instructions is ever issued.
- Assert rst_n=0 mid-stall (FULL) asynchronously between clock edges -> outputs go to reset values immediately; after release the first accepted instruction issues correctly.
